// File: rtl/sat_shift_pkg.sv
// Shared constants and helpers for the satellite shift frame.
package sat_shift_pkg;

    // Bit-order selector values for the MSB_FIRST parameter.
    localparam bit MsbFirst = 1'b1;
    localparam bit LsbFirst = 1'b0;

    // Fewer stages than this cannot resolve metastability on the async pins.
    localparam int unsigned MinSyncStages = 2;

    // Counter width able to hold 0..TOTAL+1 (TOTAL+1 is the overrun marker).
    function automatic int unsigned count_width(input int unsigned total);
        return $clog2(total + 2);
    endfunction

endpackage

// File: rtl/sat_sync_edge.sv
// Multi-flop synchroniser for one async pin, with a prev flop for edge detection.
module sat_sync_edge
    import sat_shift_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Clamp so a too-small parameter still gives a safe chain.
    localparam int unsigned Stages =
        (SYNC_STAGES < MinSyncStages) ? MinSyncStages : SYNC_STAGES;

    logic [Stages-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Next state: shift the pin into the chain, remember the last synced level.
    always_comb begin
        sync_d = {sync_q[Stages-2:0], async_i};
        prev_d = sync_q[Stages-1];
    end

    // Chain and prev flop, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge outputs compare the synced level against the previous one.
    always_comb begin
        level_o = sync_q[Stages-1];
        rise_o  = sync_q[Stages-1] & ~prev_q;
        fall_o  = ~sync_q[Stages-1] & prev_q;
    end

endmodule

// File: rtl/sat_shift_frame.sv
// Frame shift register: async shift pins synchronised to masterClk, parallel
// load, frame-length check and a protected parallel output.
module sat_shift_frame
    import sat_shift_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter bit          MSB_FIRST   = MsbFirst,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                        masterClk,
    input  logic                                        reset,
    input  logic                                        clk,
    input  logic                                        enableShift,
    input  logic                                        serialInput,
    input  logic                                        load,
    input  logic [WIDTH*CHANNELS-1:0]                   parallelInput,
    output logic [WIDTH*CHANNELS-1:0]                   parallelOutput,
    output logic                                        serialOutput,
    output logic                                        loaded,
    output logic                                        outValid,
    output logic                                        frameError,
    output logic [count_width(WIDTH*CHANNELS)-1:0]      bitCount
);

    localparam int unsigned TOTAL = WIDTH * CHANNELS;
    localparam int unsigned CNT_W = count_width(TOTAL);
    localparam logic [CNT_W-1:0] CntTotal = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CntSat   = CNT_W'(TOTAL + 1);

    logic clk_level_unused, clk_rise, clk_fall_unused;
    logic ens_level, ens_rise, ens_fall;
    logic sin_level, sin_rise_unused, sin_fall_unused;

    sat_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk_i   (masterClk),
        .rst_i   (reset),
        .async_i (clk),
        .level_o (clk_level_unused),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall_unused)
    );

    sat_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ens (
        .clk_i   (masterClk),
        .rst_i   (reset),
        .async_i (enableShift),
        .level_o (ens_level),
        .rise_o  (ens_rise),
        .fall_o  (ens_fall)
    );

    // Same depth as the clk chain so data stays aligned with its clock edge.
    sat_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sin (
        .clk_i   (masterClk),
        .rst_i   (reset),
        .async_i (serialInput),
        .level_o (sin_level),
        .rise_o  (sin_rise_unused),
        .fall_o  (sin_fall_unused)
    );

    logic [TOTAL-1:0] internal_q, internal_d;
    logic [TOTAL-1:0] par_out_q, par_out_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             active_q, active_d;
    logic             loaded_q, loaded_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_error_q, frame_error_d;

    // Next state: frame start beats shift beats frame end in the same cycle.
    always_comb begin
        internal_d    = internal_q;
        par_out_d     = par_out_q;
        bit_count_d   = bit_count_q;
        active_d      = active_q;
        loaded_d      = loaded_q;
        out_valid_d   = 1'b0;
        frame_error_d = frame_error_q;

        if (ens_rise) begin
            // A coincident clk edge is deliberately dropped here.
            active_d      = 1'b1;
            bit_count_d   = '0;
            frame_error_d = 1'b0;
            loaded_d      = load;
            if (load) begin
                internal_d = parallelInput;
            end
        end else if (clk_rise && active_q && ens_level) begin
            if (MSB_FIRST) begin
                internal_d = {internal_q[TOTAL-2:0], sin_level};
            end else begin
                internal_d = {sin_level, internal_q[TOTAL-1:1]};
            end
            if (bit_count_q != CntSat) begin
                bit_count_d = bit_count_q + 1'b1;
            end
        end else if (ens_fall && active_q) begin
            active_d = 1'b0;
            loaded_d = 1'b0;
            if (bit_count_q == CntTotal) begin
                par_out_d   = internal_q;
                out_valid_d = 1'b1;
            end else begin
                frame_error_d = 1'b1;
            end
        end
    end

    // State registers; reset dominates every event.
    always_ff @(posedge masterClk) begin
        if (reset) begin
            internal_q    <= '0;
            par_out_q     <= '0;
            bit_count_q   <= '0;
            active_q      <= 1'b0;
            loaded_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            internal_q    <= internal_d;
            par_out_q     <= par_out_d;
            bit_count_q   <= bit_count_d;
            active_q      <= active_d;
            loaded_q      <= loaded_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Outputs: serial bit comes from whichever end the frame shifts toward.
    always_comb begin
        serialOutput   = MSB_FIRST ? internal_q[TOTAL-1] : internal_q[0];
        parallelOutput = par_out_q;
        bitCount       = bit_count_q;
        loaded         = loaded_q;
        outValid       = out_valid_q;
        frameError     = frame_error_q;
    end

endmodule
